noc_config_filereg_responder: RTL and testbench
===============================================

// Module: noc_config_filereg_responder
// PURPOSE
//  Target-side endpoint for NoC configuration file-register accesses. It sits in every
//  tile, on the config virtual network ejection/injection AXI-Stream ports.
//  It decodes read/write requests from the controller tile, executes them on a local
//  NUM_REGS x 32-bit register file and returns one response packet per request.
//  One request is outstanding at a time.
// PARAMETERS
//  TDATA_WIDTH  32    AXI-Stream data width; this revision supports only 32
//  TID_WIDTH    5     transaction tag width; the tag is echoed in the response
//  TDEST_WIDTH  11    switch address width
//  TILE_ID      0     this tile's switch address; returned by reads of ID register 0xFF
//  NUM_REGS     16    number of RW registers (1..255), at addresses 0..NUM_REGS-1
//  REG_RESET    0     reset value of every RW register
// PORTS
//  aclk           in   1              clock
//  aresetn        in   1              asynchronous active-low reset
//  s_tvalid       in   1              request stream valid
//  s_tready       out  1              request stream ready
//  s_tdata        in   TDATA_WIDTH    request beat
//  s_tid          in   TID_WIDTH      request tag
//  s_tlast        in   1              last request beat
//  m_tvalid       out  1              response stream valid
//  m_tready       in   1              response stream ready
//  m_tdata        out  TDATA_WIDTH    response beat
//  m_tid          out  TID_WIDTH      echoed tag
//  m_tdest        out  TDEST_WIDTH    requester switch address
//  m_tlast        out  1              last response beat
//  cfg_regs_o     out  NUM_REGS*32    flattened register file; reg k is at [32k+31:32k]
//  cfg_wr_o       out  NUM_REGS       one-cycle one-hot write strobe, aligned with the update
// BEHAVIOUR
//  Reset: all registers = REG_RESET; outputs s_tready=1, m_tvalid=0, m_tlast=0,
//   m_tdata/m_tid/m_tdest=0, cfg_wr_o=0; FSM = IDLE. Asserting reset mid-packet aborts
//   the packet silently, with no response.
//  Request header beat: [31]=write, [26:16]=source switch address, [7:0]=reg address;
//   other bits are ignored.
//  Read request = header with tlast=1. Write request = header (tlast=0) + data beat (tlast=1).
//  Response packet, always 2 beats:
//   hdr {[31]=write echo, [30:29]=status, [26:16]=TILE_ID, [7:0]=addr}, then data (tlast=1).
//   m_tid = request tag. m_tdest = request source address.
//   Status codes: 00 OK, 01 PROTO_ERR, 10 ADDR_ERR, 11 RO_ERR.
//  Response data beat: read OK -> register value (0xFF -> zero-extended TILE_ID);
//   write OK -> the value written; any error -> 0.
//  FSM:
//   IDLE   s_tready=1; on a header handshake, latch tag/src/addr/op.
//          read                -> RESP_HDR
//          write, tlast=0      -> WDATA
//          write, tlast=1      -> PROTO_ERR, goto RESP_HDR
//   WDATA  s_tready=1; on a handshake:
//          tlast=1             -> perform the write, goto RESP_HDR
//          tlast=0             -> PROTO_ERR, no write, goto DRAIN
//   DRAIN  s_tready=1; accept and discard beats until tlast, then -> RESP_HDR
//   RESP_HDR  s_tready=0, m_tvalid=1; on m handshake -> RESP_DATA
//   RESP_DATA m_tvalid=1, m_tlast=1; on m handshake -> IDLE
//  Register update and cfg_wr_o: on the same aclk edge as the write-data handshake,
//   and only when addr < NUM_REGS. addr==0xFF -> RO_ERR; other addr >= NUM_REGS -> ADDR_ERR.
//  Latency: m_tvalid rises the cycle after the final request beat's handshake.
//   Read data is sampled on that handshake edge.
//  m_* outputs are registered and held stable while m_tvalid=1 and m_tready=0.
//  s_tready is low in both RESP states, which back-pressures the next request.
//   The earliest next-header acceptance is the cycle after the RESP_DATA handshake.
// TESTING
//  1. Write 0xDEADBEEF to reg 3, tag 5, src 0x002 -> cfg_wr_o=0x0008 for 1 cycle;
//     reg3=0xDEADBEEF; response hdr status 00, data 0xDEADBEEF, tid 5, tdest 0x002.
//  2. Read reg 3 after test 1 -> data 0xDEADBEEF, status 00. Read 0xFF with TILE_ID=6 -> data 0x6.
//  3. Write reg 20 (NUM_REGS=16) -> status 10, data 0, cfg_wr_o never set.
//     Write 0xFF -> status 11, no register changes.
//  4. Write header with tlast=1 -> status 01. 3-beat write -> status 01 after the 3rd beat
//     is drained, no write.
//  5. Hold m_tready=0 for 10 cycles -> response beats held stable, s_tready=0,
//     the next request stalls until the response completes.
//  6. Deassert aresetn while in WDATA -> all registers = REG_RESET, m_tvalid=0,
//     no response, next request is served normally.

Source files
------------

// File: rtl/noc_config_filereg_responder.sv
// NoC configuration file-register target. It decodes read/write requests on the
// config ejection stream, updates a local register file and returns a 2-beat response.
module noc_config_filereg_responder #(
    parameter int          TDATA_WIDTH = 32,
    parameter int          TID_WIDTH   = 5,
    parameter int          TDEST_WIDTH = 11,
    parameter int          TILE_ID     = 0,
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] REG_RESET   = 32'h0
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [TDATA_WIDTH-1:0]     s_tdata,
    input  logic [TID_WIDTH-1:0]       s_tid,
    input  logic                       s_tlast,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [TDATA_WIDTH-1:0]     m_tdata,
    output logic [TID_WIDTH-1:0]       m_tid,
    output logic [TDEST_WIDTH-1:0]     m_tdest,
    output logic                       m_tlast,
    output logic [NUM_REGS*32-1:0]     cfg_regs_o,
    output logic [NUM_REGS-1:0]        cfg_wr_o
);

    localparam logic [1:0]  ST_OK    = 2'b00;
    localparam logic [1:0]  ST_PROTO = 2'b01;
    localparam logic [1:0]  ST_ADDR  = 2'b10;
    localparam logic [1:0]  ST_RO    = 2'b11;
    localparam logic [10:0] TILE_ADDR  = 11'(TILE_ID);
    localparam logic [8:0]  NUM_REGS_W = 9'(NUM_REGS);

    typedef enum logic [2:0] {IDLE, WDATA, DRAIN, RESP_HDR, RESP_DATA} state_t;

    state_t                   state_q, state_d;
    logic [31:0]              regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]      cfgWr_q;
    logic                     write_q;
    logic [7:0]               addr_q;
    logic [TID_WIDTH-1:0]     tid_q;
    logic [TDEST_WIDTH-1:0]   src_q;

    logic                     mValid_q, mLast_q;
    logic [TDATA_WIDTH-1:0]   mData_q;
    logic [TID_WIDTH-1:0]     mTid_q;
    logic [TDEST_WIDTH-1:0]   mDest_q;
    logic [31:0]              respData_q;

    logic                     sHandshake, mHandshake;
    logic                     curWrite;
    logic [7:0]               curAddr;
    logic [TID_WIDTH-1:0]     curTid;
    logic [TDEST_WIDTH-1:0]   curSrc;
    logic                     addrInRange, addrIsId;
    logic [31:0]              readValue;
    logic                     loadResp, writeEn;
    logic [1:0]               respStatus;
    logic [31:0]              respData, respHdr;
    logic                     unusedBits;

    assign unusedBits = ^{s_tdata[30:27], s_tdata[15:8]};

    assign s_tready   = (state_q == IDLE) || (state_q == WDATA) || (state_q == DRAIN);
    assign sHandshake = s_tvalid && s_tready;
    assign mHandshake = mValid_q && m_tready;

    // In IDLE the header is still on the bus; afterwards the latched copy is used.
    assign curWrite = (state_q == IDLE) ? s_tdata[31]                : write_q;
    assign curAddr  = (state_q == IDLE) ? s_tdata[7:0]               : addr_q;
    assign curTid   = (state_q == IDLE) ? s_tid                      : tid_q;
    assign curSrc   = (state_q == IDLE) ? s_tdata[16 +: TDEST_WIDTH] : src_q;

    assign addrInRange = {1'b0, curAddr} < NUM_REGS_W;
    assign addrIsId    = (curAddr == 8'hFF);
    assign respHdr     = {curWrite, respStatus, 2'b00, TILE_ADDR, 8'h00, curAddr};

    always_comb begin
        readValue = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (curAddr == 8'(k)) begin
                readValue = regs_q[k];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        loadResp   = 1'b0;
        writeEn    = 1'b0;
        respStatus = ST_OK;
        respData   = '0;
        case (state_q)
            IDLE: begin
                if (sHandshake) begin
                    if (!s_tdata[31]) begin
                        loadResp = 1'b1;
                        state_d  = RESP_HDR;
                        if (addrInRange) begin
                            respData = readValue;
                        end else if (addrIsId) begin
                            respData = {21'b0, TILE_ADDR};
                        end else begin
                            respStatus = ST_ADDR;
                        end
                    end else if (s_tlast) begin
                        loadResp   = 1'b1;
                        respStatus = ST_PROTO;
                        state_d    = RESP_HDR;
                    end else begin
                        state_d = WDATA;
                    end
                end
            end
            WDATA: begin
                if (sHandshake) begin
                    if (s_tlast) begin
                        loadResp = 1'b1;
                        state_d  = RESP_HDR;
                        if (addrIsId) begin
                            respStatus = ST_RO;
                        end else if (!addrInRange) begin
                            respStatus = ST_ADDR;
                        end else begin
                            writeEn  = 1'b1;
                            respData = s_tdata[31:0];
                        end
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (sHandshake && s_tlast) begin
                    loadResp   = 1'b1;
                    respStatus = ST_PROTO;
                    state_d    = RESP_HDR;
                end
            end
            RESP_HDR: begin
                if (mHandshake) begin
                    state_d = RESP_DATA;
                end
            end
            RESP_DATA: begin
                if (mHandshake) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            tid_q   <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && sHandshake) begin
                write_q <= s_tdata[31];
                addr_q  <= s_tdata[7:0];
                tid_q   <= s_tid;
                src_q   <= s_tdata[16 +: TDEST_WIDTH];
            end
        end
    end

    // Register file update and its strobe share the write-data handshake edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= REG_RESET;
            end
            cfgWr_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                cfgWr_q[k] <= writeEn && (curAddr == 8'(k));
                if (writeEn && (curAddr == 8'(k))) begin
                    regs_q[k] <= s_tdata[31:0];
                end
            end
        end
    end

    // The header is built at request completion; the data beat waits in respData_q.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mValid_q   <= 1'b0;
            mLast_q    <= 1'b0;
            mData_q    <= '0;
            mTid_q     <= '0;
            mDest_q    <= '0;
            respData_q <= '0;
        end else if (loadResp) begin
            mValid_q   <= 1'b1;
            mLast_q    <= 1'b0;
            mData_q    <= respHdr;
            mTid_q     <= curTid;
            mDest_q    <= curSrc;
            respData_q <= respData;
        end else if (state_q == RESP_HDR && mHandshake) begin
            mData_q <= respData_q;
            mLast_q <= 1'b1;
        end else if (state_q == RESP_DATA && mHandshake) begin
            mValid_q <= 1'b0;
            mLast_q  <= 1'b0;
            mData_q  <= '0;
            mTid_q   <= '0;
            mDest_q  <= '0;
        end
    end

    assign m_tvalid = mValid_q;
    assign m_tlast  = mLast_q;
    assign m_tdata  = mData_q;
    assign m_tid    = mTid_q;
    assign m_tdest  = mDest_q;
    assign cfg_wr_o = cfgWr_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : gFlatten
        assign cfg_regs_o[32*g +: 32] = regs_q[g];
    end

endmodule

// File: tb/tb_noc_config_filereg_responder.sv
// Randomized self-checking bench for the config file-register responder, using a
// transaction-level register model with the tile's address-decode rules.
module tb_noc_config_filereg_responder;

   localparam int TILE = 6;
   localparam int NREG = 16;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        s_tvalid, s_tready, s_tlast;
   logic [31:0] s_tdata;
   logic [4:0]  s_tid;
   logic        m_tvalid, m_tready, m_tlast;
   logic [31:0] m_tdata;
   logic [4:0]  m_tid;
   logic [10:0] m_tdest;
   logic [NREG*32-1:0] cfg_regs_o;
   logic [NREG-1:0]    cfg_wr_o;

   int errors = 0;
   int checks = 0;
   logic [31:0] model [NREG];
   logic [NREG-1:0] wrSeen;
   int wrCount;

   noc_config_filereg_responder #(
      .TDATA_WIDTH(32), .TID_WIDTH(5), .TDEST_WIDTH(11),
      .TILE_ID(TILE), .NUM_REGS(NREG), .REG_RESET(32'h0)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
      .s_tid(s_tid), .s_tlast(s_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
      .m_tid(m_tid), .m_tdest(m_tdest), .m_tlast(m_tlast),
      .cfg_regs_o(cfg_regs_o), .cfg_wr_o(cfg_wr_o)
   );

   // Free-running clock
   always #5 aclk = ~aclk;

   // Watchdog so the run always ends even if the DUT wedges
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Record every write strobe observed away from the clock edge
   always @(negedge aclk) begin
      if (aresetn && cfg_wr_o != '0) begin
         wrSeen = wrSeen | cfg_wr_o;
         wrCount = wrCount + 1;
      end
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [511:0] observed,
                              input logic [511:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [511:0] flatModel();
      logic [511:0] v;
      v = '0;
      for (int k = 0; k < NREG; k++) v[32*k +: 32] = model[k];
      return v;
   endfunction

   // Expected outcome of one request, applied to the model
   task automatic modelTxn(input logic write, input int addr, input int nbeats,
                           input logic [31:0] data, output logic [1:0] status,
                           output logic [31:0] rdata, output logic [NREG-1:0] wrMask);
      status = 2'b00; rdata = 32'h0; wrMask = '0;
      if (!write) begin
         if (addr < NREG) rdata = model[addr];
         else if (addr == 255) rdata = TILE;
         else status = 2'b10;
      end else if (nbeats != 2) begin
         status = 2'b01;
      end else if (addr == 255) begin
         status = 2'b11;
      end else if (addr >= NREG) begin
         status = 2'b10;
      end else begin
         model[addr] = data;
         rdata = data;
         wrMask = NREG'(1) << addr;
      end
   endtask

   task automatic sendBeat(input logic [31:0] data, input logic [4:0] tid, input logic last);
      int waitCycles;
      waitCycles = 0;
      s_tvalid = 1'b1; s_tdata = data; s_tid = tid; s_tlast = last;
      while (!s_tready && waitCycles < 200) begin
         @(negedge aclk);
         waitCycles++;
      end
      if (!s_tready) checkOutput("s_tready_timeout", 512'(0), 512'(1));
      @(posedge aclk);
      #1;
      s_tvalid = 1'b0;
   endtask

   task automatic collectBeat(input string tag, input logic [31:0] expData, input logic expLast,
                              input logic [4:0] tid, input logic [10:0] src, input int stall);
      logic [31:0] held;
      int waitCycles;
      m_tready = 1'b0;
      held = m_tdata;
      for (int i = 0; i < stall; i++) begin
         @(negedge aclk);
         checkOutput({tag, "_held"}, 512'(m_tdata), 512'(held));
         checkOutput({tag, "_stall_valid"}, 512'(m_tvalid), 512'(1));
         checkOutput({tag, "_stall_sready"}, 512'(s_tready), 512'(0));
      end
      waitCycles = 0;
      while (!m_tvalid && waitCycles < 50) begin
         @(negedge aclk);
         waitCycles++;
      end
      checkOutput({tag, "_valid"}, 512'(m_tvalid), 512'(1));
      checkOutput({tag, "_data"}, 512'(m_tdata), 512'(expData));
      checkOutput({tag, "_last"}, 512'(m_tlast), 512'(expLast));
      checkOutput({tag, "_tid"}, 512'(m_tid), 512'(tid));
      checkOutput({tag, "_tdest"}, 512'(m_tdest), 512'(src));
      m_tready = 1'b1;
      @(posedge aclk);
      #1;
      m_tready = 1'b0;
   endtask

   // Drive one request of nbeats beats, then check the response and side effects
   task automatic applyStimulus(input logic write, input int addr, input logic [4:0] tid,
                                input logic [10:0] src, input logic [31:0] data,
                                input int nbeats, input int stall);
      logic [1:0] status;
      logic [31:0] rdata, hdr, expHdr;
      logic [NREG-1:0] wrMask;
      logic [3:0] junkA;
      logic [7:0] junkB;
      modelTxn(write, addr, nbeats, data, status, rdata, wrMask);
      wrSeen = '0; wrCount = 0;
      junkA = 4'($urandom); junkB = 8'($urandom);
      hdr = {write, junkA, src, junkB, 8'(addr)};
      expHdr = {write, status, 2'b00, 11'(TILE), 8'h00, 8'(addr)};
      if (nbeats == 1) begin
         sendBeat(hdr, tid, 1'b1);
      end else begin
         sendBeat(hdr, tid, 1'b0);
         for (int i = 1; i < nbeats; i++)
            sendBeat((i == 1) ? data : $urandom, tid, i == nbeats - 1);
      end
      checkOutput("latency_valid", 512'(m_tvalid), 512'(1));
      checkOutput("regs_at_update", cfg_regs_o, flatModel());
      collectBeat("hdr", expHdr, 1'b0, tid, src, stall);
      collectBeat("dat", rdata, 1'b1, tid, src, $urandom_range(0, 2));
      checkOutput("resp_done", 512'(m_tvalid), 512'(0));
      checkOutput("wr_strobe", 512'(wrSeen), 512'(wrMask));
      checkOutput("wr_count", 512'(wrCount), 512'((wrMask != '0) ? 1 : 0));
   endtask

   initial begin
      int kind, addrSel, addr, nb;
      aresetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tid = '0; s_tlast = 1'b0;
      m_tready = 1'b0; wrSeen = '0; wrCount = 0;
      for (int k = 0; k < NREG; k++) model[k] = 32'h0;
      repeat (3) @(negedge aclk);
      checkOutput("rst_sready", 512'(s_tready), 512'(1));
      checkOutput("rst_mvalid", 512'(m_tvalid), 512'(0));
      checkOutput("rst_mlast", 512'(m_tlast), 512'(0));
      checkOutput("rst_mdata", 512'({m_tdata, m_tid, m_tdest}), 512'(0));
      checkOutput("rst_wr", 512'(cfg_wr_o), 512'(0));
      checkOutput("rst_regs", cfg_regs_o, flatModel());
      aresetn = 1'b1;
      @(negedge aclk);

      $display("[TB] directed transactions");
      applyStimulus(1'b1, 3, 5'd5, 11'h002, 32'hDEADBEEF, 2, 0);
      applyStimulus(1'b0, 3, 5'd9, 11'h013, 32'h0, 1, 1);
      applyStimulus(1'b0, 255, 5'd1, 11'h7FF, 32'h0, 1, 0);
      applyStimulus(1'b1, 20, 5'd2, 11'h004, 32'h12345678, 2, 0);
      applyStimulus(1'b1, 255, 5'd3, 11'h005, 32'hCAFEF00D, 2, 0);
      applyStimulus(1'b0, 20, 5'd4, 11'h006, 32'h0, 1, 0);
      applyStimulus(1'b1, 7, 5'd6, 11'h007, 32'h0, 1, 0);
      applyStimulus(1'b1, 7, 5'd7, 11'h008, 32'hA5A5A5A5, 3, 0);
      applyStimulus(1'b1, 0, 5'd8, 11'h009, 32'h0BADF00D, 2, 10);
      applyStimulus(1'b1, 15, 5'd10, 11'h00A, 32'h11112222, 2, 0);
      applyStimulus(1'b0, 15, 5'd11, 11'h00B, 32'h0, 1, 0);

      $display("[TB] reset during write data phase");
      sendBeat({1'b1, 4'h0, 11'h00C, 8'h00, 8'd5}, 5'd12, 1'b0);
      @(negedge aclk);
      aresetn = 1'b0;
      for (int k = 0; k < NREG; k++) model[k] = 32'h0;
      #2;
      checkOutput("midrst_sready", 512'(s_tready), 512'(1));
      checkOutput("midrst_mvalid", 512'(m_tvalid), 512'(0));
      checkOutput("midrst_regs", cfg_regs_o, flatModel());
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      repeat (5) begin
         @(negedge aclk);
         checkOutput("midrst_noresp", 512'(m_tvalid), 512'(0));
      end
      applyStimulus(1'b1, 5, 5'd13, 11'h00D, 32'h55AA55AA, 2, 0);
      applyStimulus(1'b0, 5, 5'd14, 11'h00E, 32'h0, 1, 0);

      $display("[TB] random transactions");
      for (int t = 0; t < 60; t++) begin
         kind = $urandom_range(0, 3);
         addrSel = $urandom_range(0, 9);
         if (addrSel < 7) addr = $urandom_range(0, NREG - 1);
         else if (addrSel == 7) addr = 255;
         else if (addrSel == 8) addr = $urandom_range(NREG, 254);
         else addr = $urandom_range(0, 255);
         case (kind)
            0: nb = 1;
            1: nb = 2;
            2: nb = 1;
            default: nb = $urandom_range(3, 4);
         endcase
         applyStimulus(kind != 0, addr, 5'($urandom), 11'($urandom), $urandom, nb,
                       $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
